// File: rtl/daisy_frame_serializer_if.sv
// ---------------------------------------------------------------------------
// daisy_frame_serializer_if
//
// Bundles the chain-side input bus and the serial output of the daisy-chain
// frame serializer.
//
//   adc_ready   SAMP strobe from block logic (rising edge starts a frame)
//   p_data      chain word, BITS_ADC+1 bits; MSB=0 marks a valid ADC word
//   s_data      serial payload bit, LSB first
//   data_valid  high while s_data carries a payload (or parity) bit
//   frame_sync  pulse on bit 0 of the first word of a frame
//
// Modports:
//   master  drives the chain side, observes the serial side (bench / upstream)
//   slave   the serializer itself
// ---------------------------------------------------------------------------
interface daisy_frame_serializer_if #(
  parameter int BITS_ADC = 12
);
  logic                adc_ready;
  logic [BITS_ADC:0]   p_data;
  logic                s_data;
  logic                data_valid;
  logic                frame_sync;

  modport master (
    output adc_ready,
    output p_data,
    input  s_data,
    input  data_valid,
    input  frame_sync
  );

  modport slave (
    input  adc_ready,
    input  p_data,
    output s_data,
    output data_valid,
    output frame_sync
  );
endinterface

// File: rtl/daisy_frame_serializer.sv
// ---------------------------------------------------------------------------
// daisy_frame_serializer
//
// Downstream stage of the block daisy chain. After each rising edge of
// adc_ready it collects up to WORDS_PER_FRAME valid ADC words from the chain,
// buffers them in a small FIFO and shifts them out LSB first on a single
// s_data/data_valid pair for the row deserializer.
//
// Ports:
//   clk        row clock, rising edge
//   rst        asynchronous reset, active-high
//   bus        daisy_frame_serializer_if.slave (adc_ready, p_data in;
//              s_data, data_valid, frame_sync out)
//   ovf_clr    synchronous clear of ovf
//   ovf        sticky: a word was dropped because the FIFO was full
//   frame_err  1-cycle pulse when a new frame starts before the current ends
//   word_cnt   valid words seen in the current frame
//
// Optional feature macro: SER_PARITY_EN
//   defined   -> every word is followed by one odd-parity bit
//   undefined -> BITS_ADC bits per word, no parity logic
// ---------------------------------------------------------------------------
module daisy_frame_serializer #(
  parameter int BITS_ADC        = 12,
  parameter int WORDS_PER_FRAME = 32,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  daisy_frame_serializer_if.slave bus,
  input  logic                    ovf_clr,
  output logic                    ovf,
  output logic                    frame_err,
  output logic [5:0]              word_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
`ifdef SER_PARITY_EN
  localparam int NBITS = BITS_ADC + 1;
`else
  localparam int NBITS = BITS_ADC;
`endif
  localparam int IDX_W = $clog2(NBITS);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic                  adc_ready_d;
  logic                  start;
  logic [1:0]            state;
  logic                  sof_pending;

  logic [BITS_ADC:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  push_req;
  logic                  push_ok;
  logic                  drop;
  logic                  pop;
  logic [BITS_ADC:0]     head;
  logic [NBITS-1:0]      load_val;

  logic [NBITS-1:0]      shreg;
  logic                  busy;
  logic [IDX_W-1:0]      bit_idx;
  logic                  sof_cur;
  logic                  last_bit;

  logic                  s_data_q;
  logic                  data_valid_q;
  logic                  frame_sync_q;

  // Rising-edge detect of the sample strobe.
  assign start = bus.adc_ready & ~adc_ready_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) adc_ready_d <= 1'b0;
    else     adc_ready_d <= bus.adc_ready;
  end

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  // The word sharing a cycle with start belongs to no frame and is skipped.
  assign push_req = (state == ST_COLLECT) & ~start & ~bus.p_data[BITS_ADC];
  assign last_bit = busy & (bit_idx == IDX_W'(NBITS - 1));
  // Reload on the last bit so back-to-back words leave no gap.
  assign pop      = ~empty & (~busy | last_bit);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // Capture FSM: frame tracking, word counting and start-of-frame tagging.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      word_cnt    <= '0;
      sof_pending <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_COLLECT;
            word_cnt    <= '0;
            sof_pending <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (start) begin
            // Restart the frame; already buffered words still drain.
            frame_err   <= 1'b1;
            word_cnt    <= '0;
            sof_pending <= 1'b1;
          end else if (push_req) begin
            sof_pending <= 1'b0;
            word_cnt    <= word_cnt + 6'd1;
            if ((word_cnt + 6'd1) == 6'(WORDS_PER_FRAME)) state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky overflow; a drop outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  // Storage carries the sof tag in its MSB; no reset needed since the
  // pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {sof_pending, bus.p_data[BITS_ADC-1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

`ifdef SER_PARITY_EN
  // Odd parity: the extra bit makes the total number of ones odd.
  assign load_val = {~^head[BITS_ADC-1:0], head[BITS_ADC-1:0]};
`else
  assign load_val = head[BITS_ADC-1:0];
`endif

  // Shift register: presents bit bit_idx of the current word in shreg[0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      busy    <= 1'b0;
      bit_idx <= '0;
      sof_cur <= 1'b0;
    end else if (pop) begin
      shreg   <= load_val;
      busy    <= 1'b1;
      bit_idx <= '0;
      sof_cur <= head[BITS_ADC];
    end else if (busy) begin
      if (last_bit) begin
        busy <= 1'b0;
      end else begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + IDX_W'(1);
      end
    end
  end

  // Registered outputs, one cycle behind the shifter; s_data is forced low
  // whenever nothing is being sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_data_q     <= 1'b0;
      data_valid_q <= 1'b0;
      frame_sync_q <= 1'b0;
    end else begin
      s_data_q     <= busy & shreg[0];
      data_valid_q <= busy;
      frame_sync_q <= busy & sof_cur & (bit_idx == '0);
    end
  end

  assign bus.s_data     = s_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_sync = frame_sync_q;

endmodule

// File: tb/tb_daisy_frame_serializer.sv
// ---------------------------------------------------------------------------
// tb_daisy_frame_serializer
//
// Self-checking bench for daisy_frame_serializer. A queue-based reference
// model predicts every output each cycle; a small vector table covers the
// single-word latency case and directed sequences cover frames, overflow,
// frame restart, mid-word reset and (with SER_PARITY_EN) parity.
// ---------------------------------------------------------------------------
module tb_daisy_frame_serializer;

  localparam int BITS_ADC = 12;
  localparam int WPF      = 32;
  localparam int DEPTH    = 8;
`ifdef SER_PARITY_EN
  localparam int NBITS = BITS_ADC + 1;
`else
  localparam int NBITS = BITS_ADC;
`endif
  localparam logic [12:0] IDLE_WORD = 13'h1FFF;

  localparam int PH_IDLE    = 0;
  localparam int PH_COLLECT = 1;
  localparam int PH_DONE    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ovf_clr;
  logic       ovf;
  logic       frame_err;
  logic [5:0] word_cnt;

  daisy_frame_serializer_if #(.BITS_ADC(BITS_ADC)) bus ();

  daisy_frame_serializer #(
    .BITS_ADC(BITS_ADC),
    .WORDS_PER_FRAME(WPF),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .ovf_clr(ovf_clr),
    .ovf(ovf),
    .frame_err(frame_err),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state.
  typedef struct {
    bit sof;
    int word;
  } entry_t;

  entry_t m_q[$];
  int     m_acc_q[$];
  bit     m_ar_d;
  int     m_phase;
  int     m_cnt;
  bit     m_sof_pend;
  bit     sh_active;
  int     sh_word;
  bit     sh_sof;
  int     sh_idx;
  bit     m_s_data, m_valid, m_sync, m_ovf, m_ferr;
  int     m_out_idx;

  // Words decoded from the DUT serial output.
  int rx_q[$];
  int rx_raw_q[$];
  int sync_idx_q[$];
  int rx_word;
  int rx_n;

  bit cur_ar;

  typedef struct {
    bit          ar;
    logic [12:0] pd;
    bit          exp_valid;
    bit          exp_s;
    bit          exp_sync;
  } vec_t;

  vec_t vecs[18];
  bit   seq_a5[12] = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0};

  function automatic bit expBit(input int word, input int idx);
    if (idx < BITS_ADC) return bit'((word >> idx) & 1);
    return ($countones(word[BITS_ADC-1:0]) % 2) == 0;
  endfunction

  task automatic checkValue(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_q.delete();
    m_acc_q.delete();
    m_ar_d     = 0;
    m_phase    = PH_IDLE;
    m_cnt      = 0;
    m_sof_pend = 0;
    sh_active  = 0;
    sh_word    = 0;
    sh_sof     = 0;
    sh_idx     = 0;
    m_s_data   = 0;
    m_valid    = 0;
    m_sync     = 0;
    m_ovf      = 0;
    m_ferr     = 0;
    m_out_idx  = 0;
  endtask

  task automatic rxReset();
    rx_q.delete();
    rx_raw_q.delete();
    sync_idx_q.delete();
    rx_word = 0;
    rx_n    = 0;
  endtask

  // One clock edge of the behavioural model.
  task automatic modelStep(input bit ar, input logic [12:0] pd, input bit clr);
    bit     start, popped, dropped;
    entry_t e;
    start  = ar && !m_ar_d;
    m_ar_d = ar;

    m_valid   = sh_active;
    m_s_data  = sh_active ? expBit(sh_word, sh_idx) : 1'b0;
    m_sync    = sh_active && (sh_idx == 0) && sh_sof;
    m_out_idx = sh_idx;

    popped = 0;
    if (sh_active) begin
      if (sh_idx == NBITS - 1) begin
        if (m_q.size() > 0) popped = 1;
        else sh_active = 0;
      end else begin
        sh_idx++;
      end
    end else if (m_q.size() > 0) begin
      popped = 1;
    end
    if (popped) begin
      e         = m_q.pop_front();
      sh_word   = e.word;
      sh_sof    = e.sof;
      sh_idx    = 0;
      sh_active = 1;
    end

    m_ferr  = 0;
    dropped = 0;
    if (m_phase == PH_COLLECT) begin
      if (start) begin
        m_ferr     = 1;
        m_cnt      = 0;
        m_sof_pend = 1;
      end else if (pd[12] == 1'b0) begin
        if (m_q.size() < DEPTH) begin
          e.sof  = m_sof_pend;
          e.word = int'(pd[11:0]);
          m_q.push_back(e);
          m_acc_q.push_back(e.word);
        end else begin
          dropped = 1;
        end
        m_sof_pend = 0;
        m_cnt++;
        if (m_cnt == WPF) m_phase = PH_DONE;
      end
    end else if (m_phase == PH_IDLE) begin
      if (start) begin
        m_phase    = PH_COLLECT;
        m_cnt      = 0;
        m_sof_pend = 1;
      end
    end else begin
      m_phase = PH_IDLE;
    end

    if (dropped) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic checkOutput();
    logic [10:0] act, expv;
    act  = {bus.s_data, bus.data_valid, bus.frame_sync, ovf, frame_err, word_cnt};
    expv = {m_s_data, m_valid, m_sync, m_ovf, m_ferr, 6'(m_cnt)};
    checkValue("outputs{s,valid,sync,ovf,ferr,cnt}", int'(act), int'(expv));
    if (bus.data_valid === 1'b1) begin
      if (bus.frame_sync === 1'b1) sync_idx_q.push_back(rx_q.size());
      rx_word = rx_word | (int'(bus.s_data) << rx_n);
      rx_n++;
      if (rx_n == NBITS) begin
        rx_raw_q.push_back(rx_word);
        rx_q.push_back(rx_word & ((1 << BITS_ADC) - 1));
        rx_word = 0;
        rx_n    = 0;
      end
    end
  endtask

  task automatic applyStimulus(input bit ar, input logic [12:0] pd, input bit clr);
    bus.adc_ready = ar;
    bus.p_data    = pd;
    ovf_clr       = clr;
    cur_ar        = ar;
    @(posedge clk);
    modelStep(ar, pd, clr);
    #1;
    checkOutput();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(cur_ar, IDLE_WORD, 1'b0);
  endtask

  task automatic doReset();
    rst           = 1'b1;
    bus.adc_ready = 1'b0;
    bus.p_data    = IDLE_WORD;
    ovf_clr       = 1'b0;
    cur_ar        = 1'b0;
    #1;
    modelReset();
    rxReset();
    checkOutput();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic compareRx(input string tag);
    checkValue({tag, "_rx_count"}, rx_q.size(), m_acc_q.size());
    for (int i = 0; i < rx_q.size() && i < m_acc_q.size(); i++)
      checkValue($sformatf("%s_rx_word%0d", tag, i), rx_q[i], m_acc_q[i]);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          w;
    int          sent[$];
    int          valid_seen;
    bit          found;
    logic [12:0] pd;

    // Single word 0x0A5 from an empty FIFO: sampled at edge N (row 1),
    // bit 0 shows after edge N+2 (row 3).
    vecs[0] = '{1'b1, IDLE_WORD, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 13'h00A5,  1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, IDLE_WORD, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 12; k++)
      vecs[3 + k] = '{1'b0, IDLE_WORD, 1'b1, seq_a5[k], (k == 0)};
`ifdef SER_PARITY_EN
    vecs[15] = '{1'b0, IDLE_WORD, 1'b1, 1'b1, 1'b0};
`else
    vecs[15] = '{1'b0, IDLE_WORD, 1'b0, 1'b0, 1'b0};
`endif
    vecs[16] = '{1'b0, IDLE_WORD, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, IDLE_WORD, 1'b0, 1'b0, 1'b0};

    doReset();
    checkValue("reset_outputs", int'({bus.s_data, bus.data_valid, bus.frame_sync, ovf, frame_err, word_cnt}), 0);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].ar, vecs[i].pd, 1'b0);
      checkValue($sformatf("vec%0d{valid,s,sync}", i),
                 int'({bus.data_valid, bus.s_data, bus.frame_sync}),
                 int'({vecs[i].exp_valid, vecs[i].exp_s, vecs[i].exp_sync}));
    end

    // Full frame of 0..31, spaced so nothing is dropped.
    doReset();
    applyStimulus(1'b1, IDLE_WORD, 1'b0);
    applyStimulus(1'b0, IDLE_WORD, 1'b0);
    for (int i = 0; i < WPF; i++) begin
      applyStimulus(1'b0, 13'(i), 1'b0);
      idleCycles(13);
    end
    idleCycles(30);
    checkValue("t1_word_cnt", int'(word_cnt), 32);
    checkValue("t1_rx_count", rx_q.size(), 32);
    for (int i = 0; i < rx_q.size() && i < 32; i++)
      checkValue($sformatf("t1_word%0d", i), rx_q[i], i);
    checkValue("t1_sync_count", sync_idx_q.size(), 1);
    if (sync_idx_q.size() > 0) checkValue("t1_sync_on_word0", sync_idx_q[0], 0);

    // Contiguous burst overflows the FIFO.
    doReset();
    applyStimulus(1'b1, IDLE_WORD, 1'b0);
    applyStimulus(1'b0, IDLE_WORD, 1'b0);
    for (int i = 0; i < WPF; i++) begin
      w = int'($urandom_range(0, 4095));
      applyStimulus(1'b0, 13'(w), 1'b0);
    end
    checkValue("t3_ovf_set", int'(ovf), 1);
    idleCycles(150);
    compareRx("t3");
    checkValue("t3_ovf_sticky", int'(ovf), 1);
    applyStimulus(1'b0, IDLE_WORD, 1'b1);
    checkValue("t3_ovf_clr", int'(ovf), 0);

    // New frame after 10 words restarts the count without losing data.
    doReset();
    sent.delete();
    applyStimulus(1'b1, IDLE_WORD, 1'b0);
    applyStimulus(1'b0, IDLE_WORD, 1'b0);
    for (int i = 0; i < 10; i++) begin
      w = int'($urandom_range(0, 4095));
      sent.push_back(w);
      applyStimulus(1'b0, 13'(w), 1'b0);
      idleCycles(13);
    end
    applyStimulus(1'b1, 13'h03AA, 1'b0);
    checkValue("t4_frame_err", int'(frame_err), 1);
    checkValue("t4_word_cnt_restart", int'(word_cnt), 0);
    applyStimulus(1'b1, IDLE_WORD, 1'b0);
    checkValue("t4_frame_err_pulse_end", int'(frame_err), 0);
    applyStimulus(1'b0, 13'h0055, 1'b0);
    sent.push_back(32'h055);
    idleCycles(60);
    checkValue("t4_rx_count", rx_q.size(), 11);
    for (int i = 0; i < rx_q.size() && i < 11; i++)
      checkValue($sformatf("t4_word%0d", i), rx_q[i], sent[i]);
    checkValue("t4_sync_count", sync_idx_q.size(), 2);
    if (sync_idx_q.size() > 1) checkValue("t4_sync_second", sync_idx_q[1], 10);

    // Asynchronous reset in the middle of a word.
    doReset();
    applyStimulus(1'b1, IDLE_WORD, 1'b0);
    applyStimulus(1'b0, 13'h0FFF, 1'b0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      applyStimulus(1'b0, IDLE_WORD, 1'b0);
      if (m_valid && m_out_idx == 5) found = 1;
    end
    checkValue("t5_reached_bit5", int'(found), 1);
    rst = 1'b1;
    #1;
    checkValue("t5_async_clear{valid,s}", int'({bus.data_valid, bus.s_data}), 0);
    modelReset();
    rxReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    valid_seen = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, IDLE_WORD, 1'b0);
      if (bus.data_valid !== 1'b0) valid_seen++;
    end
    checkValue("t5_no_output_after_reset", valid_seen, 0);

`ifdef SER_PARITY_EN
    doReset();
    applyStimulus(1'b1, IDLE_WORD, 1'b0);
    applyStimulus(1'b0, 13'h0003, 1'b0);
    idleCycles(15);
    applyStimulus(1'b0, 13'h0007, 1'b0);
    idleCycles(20);
    checkValue("t6_rx_count", rx_raw_q.size(), 2);
    if (rx_raw_q.size() > 1) begin
      checkValue("t6_word3_with_parity", rx_raw_q[0], 32'h1003);
      checkValue("t6_word7_with_parity", rx_raw_q[1], 32'h0007);
    end
`endif

    // Randomised traffic against the model.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) cur_ar = ~cur_ar;
      case ($urandom_range(0, 9))
        0, 1, 2: pd = {1'b0, 12'($urandom_range(0, 4095))};
        3:       pd = {1'b1, 12'($urandom_range(0, 4095))};
        default: pd = IDLE_WORD;
      endcase
      applyStimulus(cur_ar, pd, ($urandom_range(0, 19) == 0));
    end
    cur_ar = 1'b0;
    idleCycles(200);
    compareRx("rand");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/daisy_frame_serializer.md
Name: daisy_frame_serializer

Overview:
- Downstream stage of the block daisy chain: consumes the 13-bit word stream emitted by the last block's data_to_post after each ADC sample strobe.
- Extracts valid ADC words, buffers them in a small FIFO, and serializes them LSB-first on one s_data/data_valid pair, one instance per row.
- Output format matches what the row deserializer (S2P) expects.

Parameters:
BITS_ADC, 12, ADC payload width; chain word is BITS_ADC+1 bits.
WORDS_PER_FRAME, 32, valid words per frame (8 blocks x 4 channels).
FIFO_DEPTH, 8, word FIFO depth; power of 2, at least 2.

Ports:
clk  input  1  row clock (3.2 MHz domain), rising edge
rst  input  1  asynchronous reset, active-high
adc_ready  input  1  SAMP strobe from block logic; rising edge starts a frame
p_data  input  BITS_ADC+1  chain word; bit BITS_ADC=0 means valid, all-ones means idle
ovf_clr  input  1  synchronous clear of ovf
s_data  output  1  serial data, LSB first
data_valid  output  1  high for every cycle s_data carries a payload bit
frame_sync  output  1  1-cycle pulse coincident with bit 0 of the first word of a frame
ovf  output  1  sticky flag: a word was dropped because the FIFO was full
frame_err  output  1  1-cycle pulse when a new frame starts before the current one completes
word_cnt  output  6  valid words captured in the current frame

Behaviour:
- Reset values: all outputs 0. FIFO is empty, shifter is idle, FSM is in IDLE, and adc_ready_d is 0.
- Edge detect: start = adc_ready & ~adc_ready_d, registered on clk.
- Capture FSM:
  - IDLE: start -> COLLECT, word_cnt <= 0.
  - COLLECT: each cycle with p_data[BITS_ADC]==0 pushes p_data[BITS_ADC-1:0] and increments word_cnt.
  - When word_cnt reaches WORDS_PER_FRAME (the last push) -> DONE.
  - DONE: holds word_cnt, ignores p_data, and goes to IDLE the next cycle.
  - start while in COLLECT: frame_err pulses, word_cnt <= 0, and the FSM stays in COLLECT. FIFO contents are kept.
  - p_data words arriving in the same cycle as start are not captured.
- First word of a frame: tagged in the FIFO with a 1-bit sof marker. The tag is applied to the first push after start.
- FIFO: push when full drops the word and sets ovf. A simultaneous push and pop when full is accepted (no drop). ovf_clr clears ovf; a drop in the same cycle as ovf_clr wins (ovf stays 1).
- Serializer:
  - When idle and the FIFO is not empty, it pops and loads the shift register.
  - It emits BITS_ADC bits, one per cycle, LSB first, with data_valid=1.
  - On the last bit cycle, if the FIFO is not empty, it pops the next word so the following word starts the next cycle with no gap.
- Latency: valid word sampled at edge N -> FIFO write at edge N -> pop/load at edge N+1 -> bit 0 on s_data after edge N+2 (FIFO empty, shifter idle).
- Idle outputs: when data_valid=0, s_data=0.
- frame_sync: high during bit 0 of a word carrying the sof tag.
- Reset mid-operation: rst aborts immediately. FIFO is flushed and the partial word is discarded, with no further s_data bits.

Optional Feature:
SER_PARITY_EN:
- Defined: each word is followed by one odd-parity bit over its BITS_ADC payload bits. Each word becomes BITS_ADC+1 serial bits, with data_valid high on the parity bit as well.
- Undefined: BITS_ADC bits per word and no parity logic.

Test Plan:
1. rst=1 then release; adc_ready pulse; p_data = 32 words 0x000..0x01F (bit12=0) contiguous, interleaved with 0x1FFF idles -> s_data carries 32x12 LSB-first bits matching 0..31; word_cnt=32; frame_sync exactly once, on bit 0 of word 0.
2. Single word 0x0A5 with FIFO empty, sampled at edge N -> bit 0 (1) appears after edge N+2; data_valid high 12 cycles; s_data sequence 1,0,1,0,0,1,0,1,0,0,0,0.
3. 32 contiguous valid words with FIFO_DEPTH=8 -> ovf sets once the FIFO is full; dropped words are absent from the output. ovf_clr pulse -> ovf=0.
4. Second adc_ready rising edge after 10 words -> frame_err 1-cycle pulse; word_cnt restarts at 0; all 10 buffered words are still serialized; next word carries frame_sync.
5. rst asserted mid-word (bit 5) -> data_valid and s_data go to 0 asynchronously; after release there is no output until a new frame.
6. SER_PARITY_EN defined, word 0x003 -> 13 bits, parity bit 1; word 0x007 -> parity bit 0.
